// File: rtl/scm_port_arbiter.sv
// Round-robin arbiter that serialises N_MASTERS TCDM-style requesters onto one SCM port
// and returns a single-cycle-latency response to the granted master.
module scm_port_arbiter #(
    parameter int N_MASTERS     = 4,
    parameter int ADDR_WIDTH    = 11,
    parameter int WRITE_ALLOWED = 1
) (
    input  logic                            CLK,
    input  logic                            RSTN,
    input  logic [N_MASTERS-1:0]            req_i,
    output logic [N_MASTERS-1:0]            gnt_o,
    input  logic [N_MASTERS-1:0]            wen_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] add_i,
    input  logic [N_MASTERS*32-1:0]         wdata_i,
    input  logic [N_MASTERS*4-1:0]          be_i,
    output logic [N_MASTERS-1:0]            r_valid_o,
    output logic [31:0]                     r_rdata_o,
    output logic                            r_opc_o,
    output logic                            CEN_o,
    output logic                            WEN_o,
    output logic [3:0]                      BE_o,
    output logic [ADDR_WIDTH-1:0]           A_o,
    output logic [31:0]                     D_o,
    input  logic [31:0]                     Q_i
);

    localparam int RR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [RR_W-1:0] rr_q, rr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [RR_W-1:0] rsp_id_q, rsp_id_d;
    logic            rsp_rd_q, rsp_rd_d;
    logic            rsp_err_q, rsp_err_d;

    logic            gntFound;
    logic [RR_W-1:0] winner;
    logic            accessOk;

    function automatic logic [RR_W-1:0] wrapIdx(input int base, input int offset);
        int sum;
        sum = base + offset;
        if (sum >= N_MASTERS) begin
            sum = sum - N_MASTERS;
        end
        return RR_W'(sum);
    endfunction

    // First requester at or after the pointer wins, searching modulo N_MASTERS.
    always_comb begin
        gntFound = 1'b0;
        winner   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!gntFound && req_i[wrapIdx(int'(rr_q), i)]) begin
                gntFound = 1'b1;
                winner   = wrapIdx(int'(rr_q), i);
            end
        end
    end

    // Without a grant the port shows master 0's fields; they are ignored since CEN_o is high.
    always_comb begin
        gnt_o = '0;
        WEN_o = 1'b1;
        A_o   = add_i[ADDR_WIDTH-1:0];
        D_o   = wdata_i[31:0];
        BE_o  = be_i[3:0];
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gntFound && (winner == RR_W'(i))) begin
                gnt_o[i] = 1'b1;
                WEN_o    = wen_i[i];
                A_o      = add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                D_o      = wdata_i[i*32 +: 32];
                BE_o     = be_i[i*4 +: 4];
            end
        end
    end

    assign accessOk = gntFound && (WEN_o || (WRITE_ALLOWED != 0));
    assign CEN_o    = !(RSTN && accessOk);

    always_comb begin
        rr_d        = gntFound ? wrapIdx(int'(winner), 1) : rr_q;
        rsp_valid_d = gntFound;
        rsp_id_d    = winner;
        rsp_rd_d    = gntFound && WEN_o;
        rsp_err_d   = gntFound && !WEN_o && (WRITE_ALLOWED == 0);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rd_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Read data is only meaningful for reads; writes and rejected writes answer with zero.
    always_comb begin
        r_valid_o = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            r_valid_o[i] = rsp_valid_q && (rsp_id_q == RR_W'(i));
        end
        r_rdata_o = rsp_rd_q ? Q_i : 32'h0;
        r_opc_o   = rsp_err_q;
    end

endmodule

// File: tb/tb_scm_port_arbiter.sv
// Directed bench for scm_port_arbiter: a writable and a read-only instance share the
// request inputs, each backed by a simple SCM model.
module tb_scm_port_arbiter;

    logic         CLK;
    logic         RSTN;
    logic [3:0]   req;
    logic [3:0]   wen;
    logic [43:0]  add;
    logic [127:0] wdata;
    logic [15:0]  be;

    logic [3:0]   gnt, rValid, cen4;
    logic [31:0]  rRdata, dO, q;
    logic         rOpc, cen, wenO;
    logic [3:0]   beO;
    logic [10:0]  aO;

    logic [3:0]   gntRo, rValidRo;
    logic [31:0]  rRdataRo, dORo, qRo;
    logic         rOpcRo, cenRo, wenORo;
    logic [3:0]   beORo;
    logic [10:0]  aORo;

    logic [31:0]  memA  [0:2047];
    logic [31:0]  memRo [0:2047];

    int checks   = 0;
    int failures = 0;

    scm_port_arbiter #(.N_MASTERS(4), .ADDR_WIDTH(11), .WRITE_ALLOWED(1)) dut (
        .CLK(CLK), .RSTN(RSTN), .req_i(req), .gnt_o(gnt), .wen_i(wen), .add_i(add),
        .wdata_i(wdata), .be_i(be), .r_valid_o(rValid), .r_rdata_o(rRdata), .r_opc_o(rOpc),
        .CEN_o(cen), .WEN_o(wenO), .BE_o(beO), .A_o(aO), .D_o(dO), .Q_i(q)
    );

    scm_port_arbiter #(.N_MASTERS(4), .ADDR_WIDTH(11), .WRITE_ALLOWED(0)) dutRo (
        .CLK(CLK), .RSTN(RSTN), .req_i(req), .gnt_o(gntRo), .wen_i(wen), .add_i(add),
        .wdata_i(wdata), .be_i(be), .r_valid_o(rValidRo), .r_rdata_o(rRdataRo), .r_opc_o(rOpcRo),
        .CEN_o(cenRo), .WEN_o(wenORo), .BE_o(beORo), .A_o(aORo), .D_o(dORo), .Q_i(qRo)
    );

    assign cen4 = {3'b000, cen};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] beMask(input logic [3:0] b);
        return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    // SCM models: a write lands at the edge, read data appears after the edge of a read.
    always @(posedge CLK) begin
        if (!RSTN) begin
            memA[11'h085] <= 32'hDEADBEEF;
            memA[11'h7FF] <= 32'hFFFFFFFF;
        end else if (!cen) begin
            if (!wenO) memA[aO] <= (memA[aO] & ~beMask(beO)) | (dO & beMask(beO));
            else       q <= memA[aO];
        end
    end

    always @(posedge CLK) begin
        if (!RSTN) begin
            memRo[11'h010] <= 32'h12345678;
        end else if (!cenRo) begin
            if (!wenORo) memRo[aORo] <= (memRo[aORo] & ~beMask(beORo)) | (dORo & beMask(beORo));
            else         qRo <= memRo[aORo];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic [3:0] wenV,
                                 input logic [10:0] addrV, input logic [31:0] dataV,
                                 input logic [3:0] beV);
        req   = reqV;
        wen   = wenV;
        add   = {4{addrV}};
        wdata = {4{dataV}};
        be    = {4{beV}};
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        q    = 32'h0;
        qRo  = 32'h0;
        RSTN = 1'b0;
        applyStimulus(4'b0000, 4'b1111, 11'h000, 32'h0, 4'b1111);
        step();
        step();

        // Reset: grant is still combinational, SCM disabled, responses quiet
        applyStimulus(4'b1010, 4'b1111, 11'h085, 32'h0, 4'b1111);
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'h2);
        checkOutput("rst_cen", 32'(cen), 32'h1);
        checkOutput("rst_rvalid", 32'(rValid), 32'h0);
        checkOutput("rst_rdata", rRdata, 32'h0);
        checkOutput("rst_opc", 32'(rOpc), 32'h0);
        #1;
        RSTN = 1'b1;

        // Fairness: all request continuously
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            applyStimulus(4'b1111, 4'b1111, 11'h085, 32'h0, 4'b1111);
            #1;
            checkOutput($sformatf("fair_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            if (k > 0) checkOutput($sformatf("fair_rvalid%0d", k), 32'(rValid), 32'(4'b0001 << ((k - 1) % 4)));
        end
        step();
        applyStimulus(4'b0000, 4'b1111, 11'h085, 32'h0, 4'b1111);
        #1;
        checkOutput("fair_rvalid_last", 32'(rValid), 32'h8);

        // Single read by master 2
        step();
        applyStimulus(4'b0100, 4'b1111, 11'h085, 32'h0, 4'b1111);
        #1;
        checkOutput("rd_gnt", 32'(gnt), 32'h4);
        checkOutput("rd_cen", cen4, 32'h0);
        checkOutput("rd_wen", 32'(wenO), 32'h1);
        checkOutput("rd_addr", 32'(aO), 32'h085);
        step();
        applyStimulus(4'b0000, 4'b1111, 11'h085, 32'h0, 4'b1111);
        #1;
        checkOutput("rd_rvalid", 32'(rValid), 32'h4);
        checkOutput("rd_rdata", rRdata, 32'hDEADBEEF);
        checkOutput("rd_opc", 32'(rOpc), 32'h0);

        // Write with partial byte enables, then read back
        step();
        applyStimulus(4'b0001, 4'b0000, 11'h7FF, 32'hA5A5A5A5, 4'b0011);
        #1;
        checkOutput("wr_gnt", 32'(gnt), 32'h1);
        checkOutput("wr_cen", cen4, 32'h0);
        checkOutput("wr_wen", 32'(wenO), 32'h0);
        checkOutput("wr_be", 32'(beO), 32'h3);
        checkOutput("wr_data", dO, 32'hA5A5A5A5);
        step();
        applyStimulus(4'b0010, 4'b1111, 11'h7FF, 32'h0, 4'b1111);
        #1;
        checkOutput("wr_ack_rvalid", 32'(rValid), 32'h1);
        checkOutput("wr_ack_rdata", rRdata, 32'h0);
        checkOutput("rb_gnt", 32'(gnt), 32'h2);
        step();
        applyStimulus(4'b0000, 4'b1111, 11'h000, 32'h0, 4'b1111);
        #1;
        checkOutput("rb_rvalid", 32'(rValid), 32'h2);
        checkOutput("rb_rdata", rRdata, 32'hFFFFA5A5);

        // Read-only port rejects a write from master 3
        step();
        applyStimulus(4'b1000, 4'b0000, 11'h010, 32'hCAFEF00D, 4'b1111);
        #1;
        checkOutput("ro_gnt", 32'(gntRo), 32'h8);
        checkOutput("ro_cen", 32'(cenRo), 32'h1);
        step();
        applyStimulus(4'b1000, 4'b1111, 11'h010, 32'h0, 4'b1111);
        #1;
        checkOutput("ro_rvalid", 32'(rValidRo), 32'h8);
        checkOutput("ro_opc", 32'(rOpcRo), 32'h1);
        checkOutput("ro_rdata", rRdataRo, 32'h0);
        checkOutput("ro_rd_gnt", 32'(gntRo), 32'h8);
        step();
        applyStimulus(4'b0000, 4'b1111, 11'h000, 32'h0, 4'b1111);
        #1;
        checkOutput("ro_unchanged", rRdataRo, 32'h12345678);
        checkOutput("ro_rd_opc", 32'(rOpcRo), 32'h0);
        checkOutput("rw_written", rRdata, 32'hCAFEF00D);

        // Sparse traffic: master 1 on alternate cycles
        for (int k = 0; k < 3; k++) begin
            step();
            applyStimulus(4'b0010, 4'b1111, 11'h085, 32'h0, 4'b1111);
            #1;
            checkOutput($sformatf("sp_gnt%0d", k), 32'(gnt), 32'h2);
            checkOutput($sformatf("sp_cen%0d", k), cen4, 32'h0);
            checkOutput($sformatf("sp_after_idle%0d", k), 32'(rValid), 32'h0);
            step();
            applyStimulus(4'b0000, 4'b1111, 11'h085, 32'h0, 4'b1111);
            #1;
            checkOutput($sformatf("sp_idle_cen%0d", k), cen4, 32'h1);
            checkOutput($sformatf("sp_idle_gnt%0d", k), 32'(gnt), 32'h0);
            checkOutput($sformatf("sp_rvalid%0d", k), 32'(rValid), 32'h2);
        end

        // Reset in the response cycle of a grant
        step();
        applyStimulus(4'b0100, 4'b1111, 11'h085, 32'h0, 4'b1111);
        #1;
        checkOutput("mr_gnt", 32'(gnt), 32'h4);
        step();
        checkOutput("mr_rvalid_pre", 32'(rValid), 32'h4);
        RSTN = 1'b0;
        #1;
        checkOutput("mr_rvalid_drop", 32'(rValid), 32'h0);
        checkOutput("mr_cen", cen4, 32'h1);
        applyStimulus(4'b1111, 4'b1111, 11'h085, 32'h0, 4'b1111);
        #1;
        RSTN = 1'b1;
        #1;
        checkOutput("mr_restart_gnt", 32'(gnt), 32'h1);
        step();
        checkOutput("mr_restart_rvalid", 32'(rValid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
